// File: rtl/game_timer_if.sv
// ---------------------------------------------------------------------------
// game_timer_if : start/pause/bonus controls and BCD digit/status outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface game_timer_if;
  logic       start;
  logic       pause;
  logic       add_time_counter_en;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       tick;
  logic       time_up;
  logic       warn;

  modport master (
    output start, pause, add_time_counter_en,
    input  sec_tens, sec_ones, tick, time_up, warn
  );

  modport slave (
    input  start, pause, add_time_counter_en,
    output sec_tens, sec_ones, tick, time_up, warn
  );
endinterface

`default_nettype wire

// File: rtl/game_timer.sv
// ---------------------------------------------------------------------------
// game_timer : two-digit BCD countdown clock with edge-triggered hit bonus;
// GAME_TIMER_WARN_EN enables the low-time blink on warn.      Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module game_timer #(
  parameter int TICK_DIV  = 50000000,
  parameter int START_SEC = 30,
  parameter int BONUS_SEC = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  game_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam int                   c_presc_w   = $clog2(TICK_DIV);
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_DIV - 1);
  localparam logic [c_presc_w-1:0] c_presc_one = c_presc_w'(1);
  localparam logic [7:0]           c_start_bcd = {4'(START_SEC / 10), 4'(START_SEC % 10)};
  localparam logic [3:0]           c_bonus     = 4'(BONUS_SEC);
  localparam logic [3:0]           c_bonus_m1  = 4'(BONUS_SEC - 1);

  state_t               r_state;
  state_t               w_state_n;
  logic [7:0]           r_count;
  logic [7:0]           w_count_n;
  logic [c_presc_w-1:0] r_presc;
  logic [c_presc_w-1:0] w_presc_n;
  logic                 r_en_cur;
  logic                 r_en_prev;
  logic                 r_tick;
  logic                 r_time_up;
  logic                 w_tick;
  logic                 w_bonus;

  // Adds one BCD digit to a two-digit BCD count, clamping at 99.
  function automatic logic [7:0] bcd_add_sat(input logic [7:0] cnt, input logic [3:0] d);
    logic [4:0] ones_sum;
    logic [4:0] tens_sum;
    logic [3:0] ones_new;
    logic       carry;
    ones_sum = {1'b0, cnt[3:0]} + {1'b0, d};
    if (ones_sum > 5'd9) begin
      ones_new = 4'(ones_sum - 5'd10);
      carry    = 1'b1;
    end else begin
      ones_new = ones_sum[3:0];
      carry    = 1'b0;
    end
    tens_sum = {1'b0, cnt[7:4]} + {4'b0000, carry};
    if (tens_sum > 5'd9) bcd_add_sat = 8'h99;
    else                 bcd_add_sat = {tens_sum[3:0], ones_new};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] cnt);
    if (cnt[3:0] == 4'd0) bcd_dec = {cnt[7:4] - 4'd1, 4'd9};
    else                  bcd_dec = {cnt[7:4], cnt[3:0] - 4'd1};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // A coincident bonus and tick fold into one BCD add of BONUS_SEC-1.
  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_presc_n = r_presc;
    w_tick    = 1'b0;
    w_bonus   = 1'b0;
    if (bus.start) begin
      w_state_n = RUN;
      w_count_n = c_start_bcd;
      w_presc_n = '0;
    end else if (r_state == RUN && !bus.pause) begin
      w_tick    = (r_presc == c_presc_max);
      w_bonus   = r_en_cur && !r_en_prev;
      w_presc_n = w_tick ? '0 : r_presc + c_presc_one;
      if (w_bonus) begin
        w_count_n = bcd_add_sat(r_count, w_tick ? c_bonus_m1 : c_bonus);
      end else if (w_tick) begin
        w_count_n = bcd_dec(r_count);
      end
      if (w_count_n == 8'h00) begin
        w_state_n = EXPIRED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= 8'h00;
      r_presc   <= '0;
      r_en_cur  <= 1'b0;
      r_en_prev <= 1'b0;
      r_tick    <= 1'b0;
      r_time_up <= 1'b0;
    end else begin
      r_count   <= w_count_n;
      r_presc   <= w_presc_n;
      r_en_cur  <= bus.add_time_counter_en;
      r_en_prev <= bus.start ? bus.add_time_counter_en : r_en_cur;
      r_tick    <= w_tick;
      r_time_up <= (w_state_n == EXPIRED);
    end
  end

  assign bus.sec_tens = r_count[7:4];
  assign bus.sec_ones = r_count[3:0];
  assign bus.tick     = r_tick;
  assign bus.time_up  = r_time_up;

`ifdef GAME_TIMER_WARN_EN
  localparam logic [c_presc_w-1:0] c_presc_half = c_presc_w'(TICK_DIV / 2);
  logic r_warn;

  // Evaluated on next-state values so the blink lines up with the digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= (w_state_n == RUN) && (w_count_n[7:4] == 4'd0) &&
                (w_count_n[3:0] <= 4'd5) && (w_presc_n < c_presc_half);
    end
  end

  assign bus.warn = r_warn;
`else
  assign bus.warn = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_game_timer.sv
// ---------------------------------------------------------------------------
// tb_game_timer : directed checks of game_timer on three parameter sets.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_game_timer;

`ifdef GAME_TIMER_WARN_EN
  localparam bit c_warn_on = 1'b1;
`else
  localparam bit c_warn_on = 1'b0;
`endif

  logic clk;
  logic rst_a;
  logic rst_b;
  logic rst_c;
  int   n_checks;
  int   n_errors;
  int   ticks;

  game_timer_if ifa ();
  game_timer_if ifb ();
  game_timer_if ifc ();

  game_timer #(.TICK_DIV(4),  .START_SEC(3),  .BONUS_SEC(2)) u_dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  game_timer #(.TICK_DIV(16), .START_SEC(30), .BONUS_SEC(2)) u_dut_b (.clk(clk), .rst(rst_b), .bus(ifb));
  game_timer #(.TICK_DIV(4),  .START_SEC(98), .BONUS_SEC(2)) u_dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    n_checks = 0;
    n_errors = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.start = 1'b0; ifa.pause = 1'b0; ifa.add_time_counter_en = 1'b0;
    ifb.start = 1'b0; ifb.pause = 1'b0; ifb.add_time_counter_en = 1'b0;
    ifc.start = 1'b0; ifc.pause = 1'b0; ifc.add_time_counter_en = 1'b0;
    cyc(2);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    check("rst_a_dig",  {ifa.sec_tens, ifa.sec_ones}, 8'h00);
    check("rst_a_tick", ifa.tick, 0);
    check("rst_a_up",   ifa.time_up, 0);
    check("rst_a_warn", ifa.warn, 0);
    check("rst_b_dig",  {ifb.sec_tens, ifb.sec_ones}, 8'h00);
    check("rst_b_up",   ifb.time_up, 0);
    check("rst_c_dig",  {ifc.sec_tens, ifc.sec_ones}, 8'h00);
    check("rst_c_tick", ifc.tick, 0);

    // A: plain countdown 03 -> 00 with TICK_DIV=4
    ifa.start = 1'b1; cyc(1); ifa.start = 1'b0;
    check("a_load", {ifa.sec_tens, ifa.sec_ones}, 8'h03);
    check("a_load_warn", ifa.warn, c_warn_on);
    ticks = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      ticks += int'(ifa.tick);
      check("a_dig",  {ifa.sec_tens, ifa.sec_ones}, 32'(3 - k / 4));
      check("a_tick", ifa.tick, (k % 4 == 0) ? 1 : 0);
      check("a_up",   ifa.time_up, (k == 12) ? 1 : 0);
      check("a_warn", ifa.warn, (c_warn_on && k < 12 && (k % 4) < 2) ? 1 : 0);
    end
    check("a_ticks", ticks, 3);

    // A: expired state ignores a bonus edge
    ifa.add_time_counter_en = 1'b1; cyc(4);
    check("a_exp_dig",  {ifa.sec_tens, ifa.sec_ones}, 8'h00);
    check("a_exp_up",   ifa.time_up, 1);
    check("a_exp_tick", ifa.tick, 0);
    ifa.add_time_counter_en = 1'b0; cyc(1);

    // A: restart, then bonus coincident with the tick that would reach 00
    ifa.start = 1'b1; cyc(1); ifa.start = 1'b0;
    check("a_re_dig", {ifa.sec_tens, ifa.sec_ones}, 8'h03);
    check("a_re_up",  ifa.time_up, 0);
    cyc(10);
    check("a_01_dig", {ifa.sec_tens, ifa.sec_ones}, 8'h01);
    ifa.add_time_counter_en = 1'b1; cyc(2);
    check("a_bt_dig",  {ifa.sec_tens, ifa.sec_ones}, 8'h02);
    check("a_bt_tick", ifa.tick, 1);
    check("a_bt_up",   ifa.time_up, 0);
    ifa.add_time_counter_en = 1'b0;

    // A: pause for 20 cycles freezes count and prescaler
    ifa.pause = 1'b1;
    ticks = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      ticks += int'(ifa.tick);
    end
    check("a_ps_dig",   {ifa.sec_tens, ifa.sec_ones}, 8'h02);
    check("a_ps_ticks", ticks, 0);
    check("a_ps_warn",  ifa.warn, c_warn_on);
    ifa.pause = 1'b0;
    cyc(3);
    check("a_rs_dig",  {ifa.sec_tens, ifa.sec_ones}, 8'h02);
    check("a_rs_tick", ifa.tick, 0);
    check("a_rs_warn", ifa.warn, 0);
    cyc(1);
    check("a_rs_dig2",  {ifa.sec_tens, ifa.sec_ones}, 8'h01);
    check("a_rs_tick2", ifa.tick, 1);
    check("a_rs_warn2", ifa.warn, c_warn_on);

    // B: bonus level held 10 cycles gives a single +2
    ifb.start = 1'b1; cyc(1); ifb.start = 1'b0;
    check("b_load", {ifb.sec_tens, ifb.sec_ones}, 8'h30);
    cyc(3);
    ifb.add_time_counter_en = 1'b1; cyc(10); ifb.add_time_counter_en = 1'b0;
    check("b_bonus",      {ifb.sec_tens, ifb.sec_ones}, 8'h32);
    check("b_bonus_tick", ifb.tick, 0);
    cyc(2);
    check("b_hold", {ifb.sec_tens, ifb.sec_ones}, 8'h32);
    cyc(1);
    check("b_tick_dig", {ifb.sec_tens, ifb.sec_ones}, 8'h31);
    check("b_tick",     ifb.tick, 1);
    check("b_warn",     ifb.warn, 0);

    // C: saturation at 99, then BCD carry on coincident bonus+tick at 09
    ifc.start = 1'b1; cyc(1); ifc.start = 1'b0;
    check("c_load", {ifc.sec_tens, ifc.sec_ones}, 8'h98);
    ifc.add_time_counter_en = 1'b1; cyc(2); ifc.add_time_counter_en = 1'b0;
    check("c_sat",      {ifc.sec_tens, ifc.sec_ones}, 8'h99);
    check("c_sat_tick", ifc.tick, 0);
    cyc(2);
    check("c_t1_dig", {ifc.sec_tens, ifc.sec_ones}, 8'h98);
    check("c_t1",     ifc.tick, 1);
    cyc(358);
    check("c_09", {ifc.sec_tens, ifc.sec_ones}, 8'h09);
    ifc.add_time_counter_en = 1'b1; cyc(2); ifc.add_time_counter_en = 1'b0;
    check("c_carry",      {ifc.sec_tens, ifc.sec_ones}, 8'h10);
    check("c_carry_tick", ifc.tick, 1);

    // C: reset mid-run at 17 with a start in the reset cycle
    ifc.start = 1'b1; cyc(1); ifc.start = 1'b0;
    check("c_reload", {ifc.sec_tens, ifc.sec_ones}, 8'h98);
    cyc(325);
    check("c_17", {ifc.sec_tens, ifc.sec_ones}, 8'h17);
    rst_c = 1'b1; ifc.start = 1'b1; cyc(1);
    rst_c = 1'b0; ifc.start = 1'b0;
    check("c_rst_dig",  {ifc.sec_tens, ifc.sec_ones}, 8'h00);
    check("c_rst_tick", ifc.tick, 0);
    check("c_rst_up",   ifc.time_up, 0);
    check("c_rst_warn", ifc.warn, 0);
    cyc(4);
    check("c_idle_dig", {ifc.sec_tens, ifc.sec_ones}, 8'h00);
    check("c_idle_up",  ifc.time_up, 0);
    ifc.start = 1'b1; cyc(1); ifc.start = 1'b0;
    check("c_restart", {ifc.sec_tens, ifc.sec_ones}, 8'h98);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
